// File: rtl/byte_unstriping.sv
// Receive-side 4-lane byte unstriper: captures a 4-byte group from parallel lanes
// and re-serializes it lane 0..3, with a one-group pending buffer.
module byte_unstriping (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic [7:0] rx_lane0,
  input  logic [7:0] rx_lane1,
  input  logic [7:0] rx_lane2,
  input  logic [7:0] rx_lane3,
  input  logic       rx_valid,
  output logic [7:0] rx_DataS,
  output logic       rx_ValidS,
  output logic       busy,
  output logic       overflow
);

  localparam logic [7:0] INACTIVE = 8'h00;

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_q;
  logic [1:0] cnt_q;
  logic [7:0] act1_q, act2_q, act3_q;
  logic [7:0] pend0_q, pend1_q, pend2_q, pend3_q;
  logic       pend_valid_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       busy_q;
  logic       ovf_q;

  logic       load_d;
  logic       busy_d;
  logic [7:0] next_byte_d;

  always_comb begin
    load_d = (state_q == IDLE) || (cnt_q == 2'd3);
    // After the edge we are sending unless an empty load point finds no source;
    // any surviving or newly stored pending group also keeps busy high.
    busy_d = !load_d || pend_valid_q || rx_valid;
    case (cnt_q)
      2'd0:    next_byte_d = act1_q;
      2'd1:    next_byte_d = act2_q;
      default: next_byte_d = act3_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      act1_q       <= '0;
      act2_q       <= '0;
      act3_q       <= '0;
      pend0_q      <= '0;
      pend1_q      <= '0;
      pend2_q      <= '0;
      pend3_q      <= '0;
      pend_valid_q <= 1'b0;
      data_q       <= INACTIVE;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (enb) begin
      busy_q <= busy_d;
      if (load_d) begin
        if (pend_valid_q) begin
          state_q <= SEND;
          cnt_q   <= '0;
          data_q  <= pend0_q;
          valid_q <= 1'b1;
          act1_q  <= pend1_q;
          act2_q  <= pend2_q;
          act3_q  <= pend3_q;
          // Pending drains this edge, so a coincident group refills it.
          if (rx_valid) begin
            pend0_q <= rx_lane0;
            pend1_q <= rx_lane1;
            pend2_q <= rx_lane2;
            pend3_q <= rx_lane3;
          end else begin
            pend_valid_q <= 1'b0;
          end
        end else if (rx_valid) begin
          state_q <= SEND;
          cnt_q   <= '0;
          data_q  <= rx_lane0;
          valid_q <= 1'b1;
          act1_q  <= rx_lane1;
          act2_q  <= rx_lane2;
          act3_q  <= rx_lane3;
        end else begin
          state_q <= IDLE;
          data_q  <= INACTIVE;
          valid_q <= 1'b0;
        end
      end else begin
        cnt_q   <= cnt_q + 2'd1;
        data_q  <= next_byte_d;
        valid_q <= 1'b1;
        if (rx_valid) begin
          if (!pend_valid_q) begin
            pend0_q      <= rx_lane0;
            pend1_q      <= rx_lane1;
            pend2_q      <= rx_lane2;
            pend3_q      <= rx_lane3;
            pend_valid_q <= 1'b1;
          end else begin
            ovf_q <= 1'b1;
          end
        end
      end
    end
  end

  assign rx_DataS  = data_q;
  assign rx_ValidS = valid_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_byte_unstriping.sv
// Self-checking bench for byte_unstriping: constant vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_byte_unstriping;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [31:0] lanes;
  logic        rx_valid;
  logic [7:0]  rx_DataS;
  logic        rx_ValidS;
  logic        busy;
  logic        overflow;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  byte_unstriping dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .rx_lane0 (lanes[7:0]),
    .rx_lane1 (lanes[15:8]),
    .rx_lane2 (lanes[23:16]),
    .rx_lane3 (lanes[31:24]),
    .rx_valid (rx_valid),
    .rx_DataS (rx_DataS),
    .rx_ValidS(rx_ValidS),
    .busy     (busy),
    .overflow (overflow)
  );

  // Reference model: bytes still to be shown after the current one, plus a
  // single pending group slot.
  logic [7:0]  m_rest[$];
  logic [31:0] m_pend;
  bit          m_pv;
  logic [7:0]  m_data;
  bit          m_valid;
  bit          m_ovf;

  task automatic model_reset();
    m_rest.delete();
    m_pend  = '0;
    m_pv    = 1'b0;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit rv, input logic [31:0] ln);
    bit          consumed;
    bit          have;
    logic [31:0] grp;
    consumed = 1'b0;
    have     = 1'b0;
    grp      = '0;
    if (!e) return;
    if (m_rest.size() == 0) begin
      if (m_pv) begin
        grp  = m_pend;
        m_pv = 1'b0;
        have = 1'b1;
      end else if (rv) begin
        grp      = ln;
        have     = 1'b1;
        consumed = 1'b1;
      end
      if (have) begin
        m_data  = grp[7:0];
        m_valid = 1'b1;
        m_rest  = '{grp[15:8], grp[23:16], grp[31:24]};
      end else begin
        m_data  = 8'h00;
        m_valid = 1'b0;
      end
    end else begin
      m_data  = m_rest.pop_front();
      m_valid = 1'b1;
    end
    if (rv && !consumed) begin
      if (!m_pv) begin
        m_pend = ln;
        m_pv   = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    check({name, ".data"},  rx_DataS, m_data);
    check({name, ".valid"}, {7'd0, rx_ValidS}, {7'd0, m_valid});
    check({name, ".busy"},  {7'd0, busy}, {7'd0, (m_valid || m_pv)});
    check({name, ".ovf"},   {7'd0, overflow}, {7'd0, m_ovf});
  endtask

  task automatic step(input bit e, input bit rv, input logic [31:0] ln);
    enb      = e;
    rx_valid = rv;
    lanes    = ln;
    @(posedge clk);
    model_step(e, rv, ln);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst.data",  rx_DataS, 8'h00);
    check("rst.valid", {7'd0, rx_ValidS}, 8'd0);
    check("rst.busy",  {7'd0, busy}, 8'd0);
    check("rst.ovf",   {7'd0, overflow}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          e;
    bit          rv;
    logic [31:0] ln;
    logic [7:0]  d;
    bit          v;
    bit          b;
    bit          o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit e, bit rv, logic [31:0] ln, logic [7:0] d, bit v, bit b, bit o);
    vec_t t;
    t.e = e; t.rv = rv; t.ln = ln; t.d = d; t.v = v; t.b = b; t.o = o;
    return t;
  endfunction

  logic [31:0] grp_a, grp_b, grp_c;

  initial begin
    rst      = 1'b1;
    enb      = 1'b0;
    rx_valid = 1'b0;
    lanes    = '0;
    model_reset();

    // Single group
    tbl.push_back(mk(1, 1, 32'h44332211, 8'h11, 1, 1, 0));
    tbl.push_back(mk(1, 0, 32'h0,        8'h22, 1, 1, 0));
    tbl.push_back(mk(1, 0, 32'h0,        8'h33, 1, 1, 0));
    tbl.push_back(mk(1, 0, 32'h0,        8'h44, 1, 1, 0));
    tbl.push_back(mk(1, 0, 32'h0,        8'h00, 0, 0, 0));
    // Back-to-back groups every 4 cycles
    grp_a = 32'hA3A2A1A0;
    grp_b = 32'hB3B2B1B0;
    grp_c = 32'hC3C2C1C0;
    for (int unsigned g = 0; g < 3; g++) begin
      logic [31:0] gv;
      gv = (g == 0) ? grp_a : (g == 1) ? grp_b : grp_c;
      for (int unsigned k = 0; k < 4; k++)
        tbl.push_back(mk(1, k == 0, (k == 0) ? gv : 32'h0, gv[8*k +: 8], 1, 1, 0));
    end
    tbl.push_back(mk(1, 0, 32'h0, 8'h00, 0, 0, 0));
    // Mid-group arrival goes to pending and follows without a gap
    tbl.push_back(mk(1, 1, 32'h04030201, 8'h01, 1, 1, 0));
    tbl.push_back(mk(1, 1, 32'h08070605, 8'h02, 1, 1, 0));
    for (int unsigned k = 3; k <= 8; k++)
      tbl.push_back(mk(1, 0, 32'h0, k[7:0], 1, 1, 0));
    tbl.push_back(mk(1, 0, 32'h0, 8'h00, 0, 0, 0));

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].rv, tbl[i].ln);
      check($sformatf("tbl%0d.data", i),  rx_DataS, tbl[i].d);
      check($sformatf("tbl%0d.valid", i), {7'd0, rx_ValidS}, {7'd0, tbl[i].v});
      check($sformatf("tbl%0d.busy", i),  {7'd0, busy}, {7'd0, tbl[i].b});
      check($sformatf("tbl%0d.ovf", i),   {7'd0, overflow}, {7'd0, tbl[i].o});
    end

    // Overflow: third group in a row is dropped, flag is sticky
    do_reset();
    step(1, 1, 32'h14131211); check_model("ovf0");
    step(1, 1, 32'h24232221); check_model("ovf1");
    step(1, 1, 32'h34333231); check_model("ovf2");
    check("ovf.set", {7'd0, overflow}, 8'd1);
    for (int unsigned k = 0; k < 10; k++) begin
      step(1, 0, 32'h0);
      check_model($sformatf("ovfd%0d", k));
    end
    check("ovf.held", {7'd0, overflow}, 8'd1);
    check("ovf.idle", {7'd0, rx_ValidS}, 8'd0);

    // Async reset mid-group, then a fresh group
    do_reset();
    step(1, 1, 32'h5A595857);
    step(1, 0, 32'h0);
    step(1, 1, 32'h6A696867);
    check("arst.byte2", rx_DataS, 8'h59);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst.data",  rx_DataS, 8'h00);
    check("arst.valid", {7'd0, rx_ValidS}, 8'd0);
    check("arst.busy",  {7'd0, busy}, 8'd0);
    check("arst.ovf",   {7'd0, overflow}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      step(1, k == 0, (k == 0) ? 32'h7D7C7B7A : 32'h0);
      check_model($sformatf("post%0d", k));
    end

    // Enable freeze with a stray strobe that must be ignored
    do_reset();
    step(1, 1, 32'hA3A2A1A0); check("frz.a0", rx_DataS, 8'hA0);
    step(1, 0, 32'h0);        check("frz.a1", rx_DataS, 8'hA1);
    step(0, 0, 32'h0);        check("frz.h0", rx_DataS, 8'hA1);
    step(0, 1, 32'hEEDDCCBB); check("frz.h1", rx_DataS, 8'hA1);
    step(0, 0, 32'h0);        check("frz.h2", rx_DataS, 8'hA1);
    check("frz.v", {7'd0, rx_ValidS}, 8'd1);
    step(1, 0, 32'h0);        check("frz.a2", rx_DataS, 8'hA2);
    step(1, 0, 32'h0);        check("frz.a3", rx_DataS, 8'hA3);
    step(1, 0, 32'h0);        check_model("frz.end");
    check("frz.ovf", {7'd0, overflow}, 8'd0);

    // Randomized traffic against the model
    do_reset();
    for (int unsigned k = 0; k < 400; k++) begin
      bit e, rv;
      e  = ($urandom_range(0, 9) < 8);
      rv = ($urandom_range(0, 9) < 3);
      step(e, rv, $urandom());
      check_model($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
